// File: rtl/obi_arb_pkg.sv
// -----------------------------------------------------------------------------
// obi_arb_pkg
//
// Shared definitions for the N-master OBI arbiter:
//   OBI_ADDR_W / OBI_DATA_W / OBI_BE_W : OBI bus field widths
//   MAX_MASTERS / PICK_IDX_W           : widest master vector rr_pick handles
//   rr_pick_t                          : {valid, idx} result of a pick
//   rr_pick()                          : first set request at or above a
//                                        pointer, wrapping at 'num'
// -----------------------------------------------------------------------------
package obi_arb_pkg;

    localparam int OBI_ADDR_W  = 32;
    localparam int OBI_DATA_W  = 32;
    localparam int OBI_BE_W    = 4;

    localparam int MAX_MASTERS = 8;
    localparam int PICK_IDX_W  = 3;

    typedef struct packed {
        logic                  valid;
        logic [PICK_IDX_W-1:0] idx;
    } rr_pick_t;

    // Scans req upward starting at ptr and wraps at num. Only the low 'num'
    // bits of req are considered; ptr must be below num. With ptr = 0 this
    // degenerates to a lowest-index-wins priority pick.
    function automatic rr_pick_t rr_pick(
        input logic [MAX_MASTERS-1:0] req,
        input logic [PICK_IDX_W-1:0]  ptr,
        input int unsigned            num
    );
        rr_pick_t    res;
        int unsigned k;
        res = '0;
        for (int unsigned i = 0; i < MAX_MASTERS; i++) begin
            if (i < num) begin
                k = int'(ptr) + i;
                if (k >= num) begin
                    k = k - num;
                end
                if (!res.valid && req[k]) begin
                    res.valid = 1'b1;
                    res.idx   = PICK_IDX_W'(k);
                end
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/obi_arb_id_fifo.sv
// -----------------------------------------------------------------------------
// obi_arb_id_fifo
//
// Small in-order FIFO of owner indices (one entry per accepted transfer that
// has not yet received its response).
//   clk, rst : clock, synchronous active-high reset (empties the FIFO)
//   push, din: write din at the tail (ignored when full)
//   pop      : drop the head entry (ignored when empty)
//   head     : current head entry (valid when !empty)
//   full     : DEPTH entries stored
//   empty    : no entries stored
// Storage is a circular buffer; the occupancy is kept in its own counter so
// full/empty come straight from registers.
// -----------------------------------------------------------------------------
module obi_arb_id_fifo #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    // Pointers wrap explicitly so DEPTH need not be a power of two.
    function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= bump(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= bump(rd_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/obi_arbiter_rr.sv
// -----------------------------------------------------------------------------
// obi_arbiter_rr
//
// N-master to 1-slave OBI arbiter with round-robin (or fixed-priority)
// selection and an in-order owner queue for outstanding responses.
//
// Ports:
//   clk_i, rst_i        : clock, synchronous active-high reset
//   s_req_i ... s_wdata_i: per-master request channel (packed per master)
//   s_gnt_o             : per-master grant
//   s_rvalid_o, s_rdata_o: per-master response
//   m_req_o ... m_wdata_o: muxed request channel towards the slave
//   m_gnt_i             : slave grant
//   m_rvalid_i, m_rdata_i: slave response
//   err_o               : sticky protocol error flag
//
// Handshake: a request transfer happens on a rising edge where req and gnt
// are both high. Once req is raised toward the slave it is held, with stable
// fields, until gnt is seen; the lock keeps the same master on the bus for
// that whole wait. Responses come back in request order, one per rvalid.
//
// Configuration macro: OBI_ARB_RESP_CHECK_EN
//   defined   : err_o latches on rvalid with nothing outstanding, or on
//               m_gnt_i while m_req_o is low; a $error is also reported.
//   undefined : err_o is constant 0.
// -----------------------------------------------------------------------------
module obi_arbiter_rr
    import obi_arb_pkg::*;
#(
    parameter int NUM_MASTERS     = 2,
    parameter int MAX_OUTSTANDING = 2,
    parameter int FIXED_PRIO      = 0
) (
    input  logic                                  clk_i,
    input  logic                                  rst_i,
    input  logic [NUM_MASTERS-1:0]                s_req_i,
    input  logic [NUM_MASTERS-1:0][OBI_ADDR_W-1:0] s_addr_i,
    input  logic [NUM_MASTERS-1:0][OBI_BE_W-1:0]   s_be_i,
    input  logic [NUM_MASTERS-1:0][OBI_BE_W-1:0]   s_we_i,
    input  logic [NUM_MASTERS-1:0][OBI_DATA_W-1:0] s_wdata_i,
    output logic [NUM_MASTERS-1:0]                s_gnt_o,
    output logic [NUM_MASTERS-1:0]                s_rvalid_o,
    output logic [NUM_MASTERS-1:0][OBI_DATA_W-1:0] s_rdata_o,
    output logic                                  m_req_o,
    output logic [OBI_ADDR_W-1:0]                 m_addr_o,
    output logic [OBI_BE_W-1:0]                   m_be_o,
    output logic [OBI_BE_W-1:0]                   m_we_o,
    output logic [OBI_DATA_W-1:0]                 m_wdata_o,
    input  logic                                  m_gnt_i,
    input  logic                                  m_rvalid_i,
    input  logic [OBI_DATA_W-1:0]                 m_rdata_i,
    output logic                                  err_o
);

    localparam int IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

    logic [IDX_W-1:0]       rr_ptr;
    logic                   lock_q;
    logic [IDX_W-1:0]       lock_idx;
    logic [IDX_W-1:0]       sel;
    logic                   sel_valid;
    logic [IDX_W-1:0]       head;
    logic                   full;
    logic                   empty;
    logic                   handshake;
    logic                   resp_hit;
    logic [MAX_MASTERS-1:0] req_ext;
    logic [PICK_IDX_W-1:0]  ptr_ext;
    rr_pick_t               pick;

    // Selection and request mux. A held lock overrides the arbitration
    // result so the waiting master cannot be displaced before its grant.
    always_comb begin
        req_ext                    = '0;
        req_ext[NUM_MASTERS-1:0]   = s_req_i;
        ptr_ext                    = (FIXED_PRIO != 0) ? '0 : PICK_IDX_W'(rr_ptr);
        pick                       = rr_pick(req_ext, ptr_ext, NUM_MASTERS);

        if (lock_q) begin
            sel       = lock_idx;
            sel_valid = s_req_i[lock_idx];
        end else begin
            sel       = IDX_W'(pick.idx);
            sel_valid = pick.valid;
        end

        // full comes from registered occupancy, so a pop frees a slot for
        // a new request only from the following cycle.
        m_req_o   = sel_valid & ~full;
        handshake = m_req_o & m_gnt_i;

        m_addr_o  = '0;
        m_be_o    = '0;
        m_we_o    = '0;
        m_wdata_o = '0;
        if (sel_valid) begin
            m_addr_o  = s_addr_i[sel];
            m_be_o    = s_be_i[sel];
            m_we_o    = s_we_i[sel];
            m_wdata_o = s_wdata_i[sel];
        end

        s_gnt_o = '0;
        if (handshake) begin
            s_gnt_o[sel] = 1'b1;
        end

        // Responses go to the oldest outstanding owner; an rvalid with
        // nothing outstanding is dropped.
        resp_hit   = m_rvalid_i & ~empty;
        s_rvalid_o = '0;
        s_rdata_o  = '0;
        if (resp_hit) begin
            s_rvalid_o[head] = 1'b1;
            s_rdata_o[head]  = m_rdata_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_ptr   <= '0;
            lock_q   <= 1'b0;
            lock_idx <= '0;
        end else begin
            if (handshake) begin
                lock_q <= 1'b0;
            end else if (m_req_o) begin
                lock_q   <= 1'b1;
                lock_idx <= sel;
            end
            if (handshake && (FIXED_PRIO == 0)) begin
                rr_ptr <= (sel == IDX_W'(NUM_MASTERS - 1)) ? '0 : sel + IDX_W'(1);
            end
        end
    end

    obi_arb_id_fifo #(
        .WIDTH (IDX_W),
        .DEPTH (MAX_OUTSTANDING)
    ) u_id_fifo (
        .clk   (clk_i),
        .rst   (rst_i),
        .push  (handshake),
        .pop   (resp_hit),
        .din   (sel),
        .head  (head),
        .full  (full),
        .empty (empty)
    );

`ifdef OBI_ARB_RESP_CHECK_EN
    logic err_q;
    logic proto_err;

    assign proto_err = (m_rvalid_i & empty) | (m_gnt_i & ~m_req_o);
    assign err_o     = err_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            err_q <= 1'b0;
        end else if (proto_err) begin
            err_q <= 1'b1;
        end
    end

`ifndef SYNTHESIS
    always @(posedge clk_i) begin
        if (!rst_i && proto_err) begin
            $error("obi_arbiter_rr: protocol error (rvalid=%0b empty=%0b gnt=%0b req=%0b)",
                   m_rvalid_i, empty, m_gnt_i, m_req_o);
        end
    end
`endif
`else
    assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_obi_arbiter_rr.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_obi_arbiter_rr
//
// Two arbiters side by side: index 0 is round-robin, index 1 fixed-priority,
// both NUM_MASTERS=3 / MAX_OUTSTANDING=2. A reference model tracks owner
// order as a list, the rotation as "next start index" and the lock as a
// remembered master, and predicts every output each cycle.
// -----------------------------------------------------------------------------
module tb_obi_arbiter_rr;

    localparam int N = 3;
    localparam int D = 2;
`ifdef OBI_ARB_RESP_CHECK_EN
    localparam bit EXP_STRAY_ERR = 1'b1;
`else
    localparam bit EXP_STRAY_ERR = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // ---------------- DUT signals (index 0 = rr, 1 = fixed prio) ----------------
    logic [N-1:0]         s_req    [2];
    logic [N-1:0][31:0]   s_addr   [2];
    logic [N-1:0][3:0]    s_be     [2];
    logic [N-1:0][3:0]    s_we     [2];
    logic [N-1:0][31:0]   s_wdata  [2];
    logic [N-1:0]         s_gnt    [2];
    logic [N-1:0]         s_rvalid [2];
    logic [N-1:0][31:0]   s_rdata  [2];
    logic                 m_req    [2];
    logic [31:0]          m_addr   [2];
    logic [3:0]           m_be     [2];
    logic [3:0]           m_we     [2];
    logic [31:0]          m_wdata  [2];
    logic                 m_gnt    [2];
    logic                 m_rvalid [2];
    logic [31:0]          m_rdata;
    logic                 err      [2];

    obi_arbiter_rr #(.NUM_MASTERS(N), .MAX_OUTSTANDING(D), .FIXED_PRIO(0)) u_rr (
        .clk_i(clk), .rst_i(rst),
        .s_req_i(s_req[0]), .s_addr_i(s_addr[0]), .s_be_i(s_be[0]), .s_we_i(s_we[0]),
        .s_wdata_i(s_wdata[0]), .s_gnt_o(s_gnt[0]), .s_rvalid_o(s_rvalid[0]),
        .s_rdata_o(s_rdata[0]), .m_req_o(m_req[0]), .m_addr_o(m_addr[0]),
        .m_be_o(m_be[0]), .m_we_o(m_we[0]), .m_wdata_o(m_wdata[0]),
        .m_gnt_i(m_gnt[0]), .m_rvalid_i(m_rvalid[0]), .m_rdata_i(m_rdata),
        .err_o(err[0])
    );

    obi_arbiter_rr #(.NUM_MASTERS(N), .MAX_OUTSTANDING(D), .FIXED_PRIO(1)) u_fp (
        .clk_i(clk), .rst_i(rst),
        .s_req_i(s_req[1]), .s_addr_i(s_addr[1]), .s_be_i(s_be[1]), .s_we_i(s_we[1]),
        .s_wdata_i(s_wdata[1]), .s_gnt_o(s_gnt[1]), .s_rvalid_o(s_rvalid[1]),
        .s_rdata_o(s_rdata[1]), .m_req_o(m_req[1]), .m_addr_o(m_addr[1]),
        .m_be_o(m_be[1]), .m_we_o(m_we[1]), .m_wdata_o(m_wdata[1]),
        .m_gnt_i(m_gnt[1]), .m_rvalid_i(m_rvalid[1]), .m_rdata_i(m_rdata),
        .err_o(err[1])
    );

    // ---------------- scoreboard counters ----------------
    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    bit mlock     [2];
    int mlock_idx [2];
    int mrr       [2];
    bit merr      [2];
    bit pend      [2][N];
    int q0 [$];
    int q1 [$];

    function automatic int q_size(input int k);
        return (k == 0) ? q0.size() : q1.size();
    endfunction

    function automatic int q_front(input int k);
        return (k == 0) ? q0[0] : q1[0];
    endfunction

    function automatic void q_push(input int k, input int v);
        if (k == 0) q0.push_back(v);
        else        q1.push_back(v);
    endfunction

    function automatic void q_pop(input int k);
        if (k == 0) void'(q0.pop_front());
        else        void'(q1.pop_front());
    endfunction

    // Winner = locked master, else the requester with the smallest distance
    // from the start index (start is always 0 for fixed priority).
    function automatic void model_sel(input int k, output int sel, output bit present);
        int bestd;
        int d;
        sel     = 0;
        present = 1'b0;
        if (mlock[k]) begin
            sel     = mlock_idx[k];
            present = s_req[k][sel];
        end else begin
            bestd = N;
            for (int i = 0; i < N; i++) begin
                if (s_req[k][i]) begin
                    d = (k == 1) ? i : (i - mrr[k] + N) % N;
                    if (d < bestd) begin
                        bestd   = d;
                        sel     = i;
                        present = 1'b1;
                    end
                end
            end
        end
    endfunction

    function automatic void model_reset();
        for (int k = 0; k < 2; k++) begin
            mlock[k] = 0; mlock_idx[k] = 0; mrr[k] = 0; merr[k] = 0;
            for (int i = 0; i < N; i++) pend[k][i] = 0;
        end
        q0.delete();
        q1.delete();
    endfunction

    task automatic check_outputs(input int k);
        int sel;
        bit present;
        bit ereq;
        logic [N-1:0]       egnt;
        logic [N-1:0]       ervalid;
        logic [N-1:0][31:0] erdata;
        string p;
        p = (k == 0) ? "rr" : "fp";
        model_sel(k, sel, present);
        ereq = present && (q_size(k) < D);
        egnt = '0;
        if (ereq && m_gnt[k]) egnt[sel] = 1'b1;
        ervalid = '0;
        erdata  = '0;
        if (m_rvalid[k] && q_size(k) > 0) begin
            ervalid[q_front(k)] = 1'b1;
            erdata[q_front(k)]  = m_rdata;
        end
        check_eq({p, ".m_req"},   m_req[k],   ereq);
        check_eq({p, ".m_addr"},  m_addr[k],  present ? s_addr[k][sel]  : 32'h0);
        check_eq({p, ".m_be"},    m_be[k],    present ? s_be[k][sel]    : 4'h0);
        check_eq({p, ".m_we"},    m_we[k],    present ? s_we[k][sel]    : 4'h0);
        check_eq({p, ".m_wdata"}, m_wdata[k], present ? s_wdata[k][sel] : 32'h0);
        check_eq({p, ".s_gnt"},   s_gnt[k],   egnt);
        check_eq({p, ".s_rvalid"}, s_rvalid[k], ervalid);
        check_eq({p, ".s_rdata"}, s_rdata[k], erdata);
        check_eq({p, ".err"},     err[k],     merr[k]);
    endtask

    function automatic void model_update(input int k);
        int sel;
        bit present;
        bit ereq;
        bit hs;
        model_sel(k, sel, present);
        ereq = present && (q_size(k) < D);
        hs   = ereq && m_gnt[k];
`ifdef OBI_ARB_RESP_CHECK_EN
        if ((m_rvalid[k] && q_size(k) == 0) || (m_gnt[k] && !ereq)) merr[k] = 1'b1;
`endif
        if (m_rvalid[k] && q_size(k) > 0) q_pop(k);
        if (hs) begin
            q_push(k, sel);
            pend[k][sel] = 1'b0;
            if (k == 0) mrr[k] = (sel + 1) % N;
            mlock[k] = 1'b0;
        end else if (ereq) begin
            mlock[k]     = 1'b1;
            mlock_idx[k] = sel;
        end
    endfunction

    // ---------------- driver tasks ----------------
    task automatic set_idle(input int k);
        s_req[k]    = '0;
        s_addr[k]   = '0;
        s_be[k]     = '0;
        s_we[k]     = '0;
        s_wdata[k]  = '0;
        m_gnt[k]    = 1'b0;
        m_rvalid[k] = 1'b0;
    endtask

    task automatic set_master(input int k, input int i, input logic [31:0] a);
        s_addr[k][i]  = a;
        s_be[k][i]    = a[3:0] ^ 4'hF;
        s_we[k][i]    = 4'(i + 1);
        s_wdata[k][i] = ~a;
    endtask

    // Inputs are driven 1 ns after the rising edge; outputs are compared on
    // the falling edge; the model steps just before the next rising edge.
    task automatic settle();
        @(negedge clk);
        check_outputs(0);
        check_outputs(1);
    endtask

    task automatic advance();
        model_update(0);
        model_update(1);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        set_idle(0);
        set_idle(1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    // OBI-compliant random masters: a request, once raised, stays with the
    // same fields until the model sees it granted.
    task automatic drive_random();
        int sel;
        bit present;
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < N; i++) begin
                if (!pend[k][i] && $urandom_range(0, 99) < 40) begin
                    pend[k][i]    = 1'b1;
                    s_addr[k][i]  = $urandom;
                    s_be[k][i]    = 4'($urandom_range(0, 15));
                    s_we[k][i]    = 4'($urandom_range(0, 15));
                    s_wdata[k][i] = $urandom;
                end
                s_req[k][i] = pend[k][i];
            end
            model_sel(k, sel, present);
            m_gnt[k]    = present && (q_size(k) < D) && ($urandom_range(0, 99) < 55);
            m_rvalid[k] = (q_size(k) > 0) && ($urandom_range(0, 99) < 50);
        end
        m_rdata = $urandom;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        m_rdata = '0;
        model_reset();
        do_reset();

        // Reset state.
        settle();
        check_eq("reset.m_req", m_req[0], 1'b0);
        check_eq("reset.err", err[0], 1'b0);
        advance();

        // Round-robin rotation with immediate grants; responses one cycle later.
        do_reset();
        for (int i = 0; i < N; i++) set_master(0, i, 32'h1000 + 32'(i * 4));
        for (int c = 0; c < 5; c++) begin
            s_req[0]    = (c < 4) ? 3'b111 : 3'b000;
            m_gnt[0]    = (c < 4);
            m_rvalid[0] = (c > 0);
            m_rdata     = 32'hA000_0000 + 32'(c);
            settle();
            if (c < 4) check_eq("t1.gnt", s_gnt[0], 3'b001 << (c % 3));
            if (c > 0) check_eq("t1.rvalid", s_rvalid[0], 3'b001 << ((c - 1) % 3));
            advance();
        end

        // Fixed priority: m0 beats m2, then m2 alone.
        do_reset();
        set_master(1, 0, 32'h0000_2000);
        set_master(1, 2, 32'h0000_2200);
        s_req[1] = 3'b101;
        m_gnt[1] = 1'b1;
        settle();
        check_eq("t2.first", s_gnt[1], 3'b001);
        advance();
        s_req[1] = 3'b100;
        settle();
        check_eq("t2.second", s_gnt[1], 3'b100);
        advance();
        set_idle(1);

        // Lock: m1 waits three cycles, m0 joins in the third, m1 keeps the bus.
        do_reset();
        set_master(0, 0, 32'h0000_0A00);
        set_master(0, 1, 32'h0000_0B00);
        s_req[0] = 3'b010;
        for (int c = 0; c < 3; c++) begin
            if (c == 2) s_req[0] = 3'b011;
            settle();
            check_eq("t3.addr_hold", m_addr[0], 32'h0000_0B00);
            check_eq("t3.no_gnt", s_gnt[0], 3'b000);
            advance();
        end
        m_gnt[0] = 1'b1;
        settle();
        check_eq("t3.gnt_m1", s_gnt[0], 3'b010);
        advance();
        s_req[0] = 3'b001;
        settle();
        check_eq("t3.gnt_m0", s_gnt[0], 3'b001);
        check_eq("t3.addr_m0", m_addr[0], 32'h0000_0A00);
        advance();

        // Full queue blocks requests; first response to first owner.
        do_reset();
        for (int i = 0; i < N; i++) set_master(0, i, 32'h3000 + 32'(i * 16));
        s_req[0] = 3'b001; m_gnt[0] = 1'b1;
        settle(); check_eq("t4.gnt0", s_gnt[0], 3'b001); advance();
        s_req[0] = 3'b010;
        settle(); check_eq("t4.gnt1", s_gnt[0], 3'b010); advance();
        s_req[0] = 3'b100; m_gnt[0] = 1'b0;
        settle(); check_eq("t4.full_req", m_req[0], 1'b0); advance();
        m_rvalid[0] = 1'b1; m_rdata = 32'hDEAD_BEEF;
        settle();
        check_eq("t4.rvalid", s_rvalid[0], 3'b001);
        check_eq("t4.rdata", s_rdata[0][0], 32'hDEAD_BEEF);
        check_eq("t4.still_full", m_req[0], 1'b0);
        advance();
        m_rvalid[0] = 1'b0; m_gnt[0] = 1'b1;
        settle();
        check_eq("t4.reopen", m_req[0], 1'b1);
        check_eq("t4.gnt2", s_gnt[0], 3'b100);
        advance();

        // Same-cycle grant and response with one outstanding.
        s_req[0] = 3'b000; m_gnt[0] = 1'b0; m_rvalid[0] = 1'b1; m_rdata = 32'h1111_1111;
        settle(); check_eq("t5.drain", s_rvalid[0], 3'b010); advance();
        s_req[0] = 3'b001; m_gnt[0] = 1'b1; m_rdata = 32'h2222_2222;
        settle();
        check_eq("t5.rvalid", s_rvalid[0], 3'b100);
        check_eq("t5.gnt", s_gnt[0], 3'b001);
        advance();
        s_req[0] = 3'b000; m_gnt[0] = 1'b0; m_rdata = 32'h3333_3333;
        settle();
        check_eq("t5.behind", s_rvalid[0], 3'b001);
        check_eq("t5.rdata", s_rdata[0][0], 32'h3333_3333);
        advance();
        m_rvalid[0] = 1'b0;

        // Reset with two outstanding, then a stray response.
        do_reset();
        set_master(0, 0, 32'h4000); set_master(0, 1, 32'h4100);
        s_req[0] = 3'b001; m_gnt[0] = 1'b1; settle(); advance();
        s_req[0] = 3'b010; settle(); advance();
        do_reset();
        m_rvalid[0] = 1'b1; m_rdata = 32'h0000_0BAD;
        settle();
        check_eq("t6.stray", s_rvalid[0], 3'b000);
        advance();
        m_rvalid[0] = 1'b0;
        settle();
        check_eq("t6.err", err[0], EXP_STRAY_ERR);
        advance();

        // Randomized traffic with occasional resets.
        do_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if ($urandom_range(0, 499) == 0) do_reset();
            drive_random();
            settle();
            advance();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/obi_arbiter_rr.md
Name: obi_arbiter_rr

Overview:
- Parametrised N-master to 1-slave OBI arbiter for the testbench wrapper. Successor to the fixed two-master priority arbiter.
- Arbitrates with round-robin; optional fixed-priority mode selected by parameter.
- Supports up to MAX_OUTSTANDING accepted-but-unanswered transfers by queuing owner IDs in order.
- Responses (rvalid/rdata) are routed in order to the master whose grant is oldest.

Parameters:
- NUM_MASTERS, 2, number of requesting masters (2..8).
- MAX_OUTSTANDING, 2, depth of owner-ID queue (1..8; power of two not required).
- FIXED_PRIO, 0, 1 = lowest index always wins; 0 = round-robin.
- IDX_W, $clog2(NUM_MASTERS) (min 1), derived owner-index width.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- s_req_i  in  NUM_MASTERS  per-master request.
- s_addr_i  in  NUM_MASTERS x 32  per-master address.
- s_be_i  in  NUM_MASTERS x 4  per-master byte enables.
- s_we_i  in  NUM_MASTERS x 4  per-master write enables.
- s_wdata_i  in  NUM_MASTERS x 32  per-master write data.
- s_gnt_o  out  NUM_MASTERS  per-master grant.
- s_rvalid_o  out  NUM_MASTERS  per-master response valid.
- s_rdata_o  out  NUM_MASTERS x 32  per-master read data.
- m_req_o  out  1  slave-side request.
- m_addr_o  out  32  muxed address.
- m_be_o  out  4  muxed byte enables.
- m_we_o  out  4  muxed write enables.
- m_wdata_o  out  32  muxed write data.
- m_gnt_i  in  1  slave grant.
- m_rvalid_i  in  1  slave response valid.
- m_rdata_i  in  32  slave read data.
- err_o  out  1  sticky protocol error (only with OBI_ARB_RESP_CHECK_EN).

Behaviour:
- Reset (rst_i high at a clock edge):
  - queue emptied; rr pointer = 0; lock cleared; err_o = 0.
  - Outputs are combinational from this state and inputs.
  - Any in-flight transfer is abandoned; later rvalids are handled as in the empty-queue case.
- Selection (combinational):
  - If lock set, sel = locked index.
  - Otherwise, FIXED_PRIO=1: sel = lowest set s_req_i.
  - Otherwise, round-robin: sel = first set s_req_i scanning upward from rr pointer, wrapping at NUM_MASTERS.
- m_req_o = s_req_i[sel] & ~full. No request is issued while the queue is full.
- m_addr/be/we/wdata = fields of sel. All-zero when no request is present.
- s_gnt_o[sel] = m_gnt_i & m_req_o. All other s_gnt_o bits are 0.
- Lock (OBI stability):
  - If m_req_o=1 and m_gnt_i=0, latch sel into the lock on the next edge.
  - Clear the lock on the handshake cycle.
  - The locked master keeps the bus even if a higher-priority request appears.
- Handshake (m_req_o & m_gnt_i): on the edge, push sel into the queue. In round-robin mode, rr pointer <= (sel+1) mod NUM_MASTERS.
- Response:
  - When m_rvalid_i=1 and the queue is non-empty, s_rvalid_o[head]=1 and s_rdata_o[head]=m_rdata_i.
  - All other masters see rvalid=0 and rdata=0. Pop the head on the edge.
- Same-cycle handshake and rvalid:
  - Push and pop both occur; count is unchanged.
  - If full, m_req_o is already 0, so no push occurs.
  - A pop from a full queue re-enables m_req_o only in the next cycle (full is registered-state based).
- rvalid with empty queue: all s_rvalid_o=0; response dropped; no queue change.
- Latency:
  - Request to slave: 0 cycles (combinational).
  - Grant back: 0 cycles.
  - rvalid routing: 0 cycles.
- Queue storage: circular buffer with wr/rd pointers. Pointers wrap at MAX_OUTSTANDING-1 to 0. Count is held in a separate register of $clog2(MAX_OUTSTANDING+1) bits.

Optional Feature:
- Macro OBI_ARB_RESP_CHECK_EN.
- Defined:
  - err_o is set and held until reset on either of: rvalid with an empty queue; or m_gnt_i=1 while m_req_o=0.
  - A simulation $error is emitted at the same time.
- Undefined: err_o is tied to 0, with no checker logic and no messages.

Decomposition:
- Package obi_arb_pkg holds:
  - constant OBI_ADDR_W=32, OBI_DATA_W=32, OBI_BE_W=4;
  - a function rr_pick(req vector, pointer) returning index plus valid.
- Sub-module obi_arb_id_fifo: owner-index FIFO with push, pop, head, full, empty.
  - Generic width and depth.
  - Synchronous active-high reset.

Test Plan:
- NUM_MASTERS=3, RR: all three s_req_i held high with immediate m_gnt_i each cycle -> grants rotate 0,1,2,0. rvalid one cycle later routes in the same order.
- FIXED_PRIO=1: m0 and m2 request together -> m0 granted first. With m0 deasserted, m2 granted next cycle.
- m1 requests; m_gnt_i held low 3 cycles; m0 raises req in cycle 2 -> addr stays m1's until the grant. m0 is granted afterwards.
- MAX_OUTSTANDING=2: two grants without rvalid -> m_req_o=0 while full. First rvalid (rdata=0xDEADBEEF) goes to the first owner; m_req_o=1 next cycle.
- Same-cycle grant and rvalid with count=1 -> count stays 1; head advances; the new owner is queued behind.
- rst_i pulsed with 2 outstanding, then a stray rvalid -> no s_rvalid_o asserted. With OBI_ARB_RESP_CHECK_EN, err_o=1.
